// File: rtl/fetch_decode_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_reg
// Description : IF/ID pipeline register. Captures fetched 16-bit words with
//               their PC, merges two-word (opcode + immediate) instructions
//               into a single Decode packet, and supports stall (hold) and
//               flush (bubble insertion).
//               Optional macro FD_PERF_CNT_EN adds saturating perf_instr /
//               perf_bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_reg #(
    parameter int INST_W       = 16,
    parameter int PC_W         = 32,
    parameter int IMM_FLAG_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [INST_W-1:0] out_imm,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_npc,
    output logic              imm_pending
`ifdef FD_PERF_CNT_EN
    ,
    output logic [15:0]       perf_instr,
    output logic [15:0]       perf_bubble
`endif
);

    localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [INST_W-1:0]   hold_inst_q, hold_inst_d;
    logic [PC_W-1:0]     hold_pc_q,   hold_pc_d;
    logic                out_valid_q, out_valid_d;
    logic [INST_W-1:0]   out_inst_q,  out_inst_d;
    logic [INST_W-1:0]   out_imm_q,   out_imm_d;
    logic [PC_W-1:0]     out_pc_q,    out_pc_d;
    logic [PC_W-1:0]     out_npc_q,   out_npc_d;

    // Next-state logic: flush beats stall, stall freezes everything.
    always_comb begin
        state_d     = state_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_imm_d   = out_imm_q;
        out_pc_d    = out_pc_q;
        out_npc_d   = out_npc_q;

        if (flush) begin
            // Drop any half-assembled instruction and emit a clean bubble.
            state_d     = S_FIRST;
            hold_inst_d = '0;
            hold_pc_d   = '0;
            out_valid_d = 1'b0;
            out_inst_d  = '0;
            out_imm_d   = '0;
            out_pc_d    = '0;
            out_npc_d   = '0;
        end else if (!stall) begin
            case (state_q)
                S_FIRST: begin
                    if (!in_valid) begin
                        out_valid_d = 1'b0;
                    end else if (!in_inst[IMM_FLAG_BIT]) begin
                        out_inst_d  = in_inst;
                        out_imm_d   = '0;
                        out_pc_d    = in_pc;
                        out_npc_d   = in_pc + C_PC_ONE;
                        out_valid_d = 1'b1;
                    end else begin
                        // Opcode of a two-word instruction: park it and bubble.
                        hold_inst_d = in_inst;
                        hold_pc_d   = in_pc;
                        out_valid_d = 1'b0;
                        state_d     = S_IMM;
                    end
                end
                S_IMM: begin
                    if (!in_valid) begin
                        out_valid_d = 1'b0;
                    end else begin
                        // Immediate word; its flag bit carries no meaning.
                        out_inst_d  = hold_inst_q;
                        out_imm_d   = in_inst;
                        out_pc_d    = hold_pc_q;
                        out_npc_d   = in_pc + C_PC_ONE;
                        out_valid_d = 1'b1;
                        state_d     = S_FIRST;
                    end
                end
                default: begin
                    state_d = S_FIRST;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FIRST;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_npc_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_imm_q   <= out_imm_d;
            out_pc_q    <= out_pc_d;
            out_npc_q   <= out_npc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_npc     = out_npc_q;
    assign imm_pending = (state_q == S_IMM);

`ifdef FD_PERF_CNT_EN
    logic [15:0] perf_instr_q;
    logic [15:0] perf_bubble_q;
    logic        instr_inc;
    logic        bubble_inc;

    // A valid packet is issued only on a non-stalled, non-flushed edge;
    // a bubble is any other non-stalled edge (flush counts as a bubble).
    always_comb begin
        instr_inc  = !flush && !stall && out_valid_d;
        bubble_inc = flush || (!stall && !out_valid_d);
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_instr_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (instr_inc && (perf_instr_q != 16'hFFFF)) begin
                perf_instr_q <= perf_instr_q + 16'd1;
            end
            if (bubble_inc && (perf_bubble_q != 16'hFFFF)) begin
                perf_bubble_q <= perf_bubble_q + 16'd1;
            end
        end
    end

    assign perf_instr  = perf_instr_q;
    assign perf_bubble = perf_bubble_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_reg
// Description : Self-checking bench for fetch_decode_reg. Each cycle the
//               expected Decode packet is queued when stimulus is driven and
//               popped for comparison after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_reg;

    typedef struct packed {
        logic        v;
        logic [15:0] inst;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pend;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_inst;
    logic [31:0] in_pc;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [15:0] out_imm;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic        imm_pending;
`ifdef FD_PERF_CNT_EN
    logic [15:0] perf_instr;
    logic [15:0] perf_bubble;
    int          m_instr;
    int          m_bubble;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    pkt_t exp_q[$];
    pkt_t e;
    pkt_t o;

    fetch_decode_reg #(.INST_W(16), .PC_W(32), .IMM_FLAG_BIT(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_npc    (out_npc),
        .imm_pending(imm_pending)
`ifdef FD_PERF_CNT_EN
        ,
        .perf_instr (perf_instr),
        .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    function automatic pkt_t mk(input logic v, input logic [15:0] inst,
                                input logic [15:0] imm, input logic [31:0] pc,
                                input logic [31:0] npc, input logic pend);
        pkt_t p;
        p.v = v; p.inst = inst; p.imm = imm; p.pc = pc; p.npc = npc; p.pend = pend;
        return p;
    endfunction

    function automatic pkt_t sample();
        return mk(out_valid, out_inst, out_imm, out_pc, out_npc, imm_pending);
    endfunction

    task automatic drive(input logic rst, input logic vld, input logic [15:0] inst,
                         input logic [31:0] pc, input logic stl, input logic fls);
        reset = rst; in_valid = vld; in_inst = inst; in_pc = pc; stall = stl; flush = fls;
    endtask

    // Queue the expectation for the coming edge, advance, sample region.
    task automatic tick(input pkt_t ex);
        exp_q.push_back(ex);
`ifdef FD_PERF_CNT_EN
        if (reset) begin
            m_instr = 0; m_bubble = 0;
        end else if (flush) begin
            if (m_bubble < 16'hFFFF) m_bubble++;
        end else if (!stall) begin
            if (ex.v) begin
                if (m_instr < 16'hFFFF) m_instr++;
            end else if (m_bubble < 16'hFFFF) begin
                m_bubble++;
            end
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0, 1: begin drive(1, 1, 16'hABCD, 32'h10, 0, 0); tick(mk(0, 0, 0, 0, 0, 0)); end
                default: begin drive(0, 1, 16'h1234, 32'h20, 0, 0); tick(mk(1, 16'h1234, 0, 32'h20, 32'h21, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_two_word();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0: begin drive(0, 1, 16'h4001, 32'h30, 0, 0); tick(mk(0, 16'h1234, 0, 32'h20, 32'h21, 1)); end
                default: begin drive(0, 1, 16'hBEEF, 32'h31, 0, 0); tick(mk(1, 16'h4001, 16'hBEEF, 32'h30, 32'h32, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL two_word[%0d]: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin drive(0, 1, 16'h1234, 32'h40, 0, 0); tick(mk(1, 16'h1234, 0, 32'h40, 32'h41, 0)); end
                1, 2, 3: begin
                    drive(0, 1, 16'h1110 + 16'(i * 2), 32'h100 + i, 1, 0);
                    tick(mk(1, 16'h1234, 0, 32'h40, 32'h41, 0));
                end
                4: begin drive(0, 1, 16'h4001, 32'h50, 0, 0); tick(mk(0, 16'h1234, 0, 32'h40, 32'h41, 1)); end
                5, 6: begin drive(0, 1, 16'h7776, 32'h200, 1, 0); tick(mk(0, 16'h1234, 0, 32'h40, 32'h41, 1)); end
                default: begin drive(0, 1, 16'h6666, 32'h51, 0, 0); tick(mk(1, 16'h4001, 16'h6666, 32'h50, 32'h52, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin drive(0, 1, 16'h4001, 32'h60, 0, 0); tick(mk(0, 16'h4001, 16'h6666, 32'h50, 32'h52, 1)); end
                1: begin drive(0, 1, 16'h9999, 32'h61, 1, 1); tick(mk(0, 0, 0, 0, 0, 0)); end
                2: begin drive(0, 1, 16'h2222, 32'h61, 0, 0); tick(mk(1, 16'h2222, 0, 32'h61, 32'h62, 0)); end
                3: begin drive(0, 1, 16'h3333, 32'h62, 0, 1); tick(mk(0, 0, 0, 0, 0, 0)); end
                default: begin drive(0, 1, 16'h2222, 32'h61, 0, 0); tick(mk(1, 16'h2222, 0, 32'h61, 32'h62, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin drive(0, 1, 16'h4001, 32'h70, 0, 0); tick(mk(0, 16'h2222, 0, 32'h61, 32'h62, 1)); end
                1, 2: begin drive(0, 0, 16'hDEAD, 32'h71, 0, 0); tick(mk(0, 16'h2222, 0, 32'h61, 32'h62, 1)); end
                default: begin drive(0, 1, 16'h5555, 32'h73, 0, 0); tick(mk(1, 16'h4001, 16'h5555, 32'h70, 32'h74, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL gap[%0d]: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            case (i)
                0: begin drive(0, 1, 16'h0002, 32'hFFFF_FFFF, 0, 0); tick(mk(1, 16'h0002, 0, 32'hFFFF_FFFF, 32'h0, 0)); end
                default: begin drive(0, 0, 16'h0000, 32'h0, 0, 0); tick(mk(0, 16'h0002, 0, 32'hFFFF_FFFF, 32'h0, 0)); end
            endcase
            e = exp_q.pop_front(); o = sample(); n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, o, e);
            end
`ifdef FD_PERF_CNT_EN
            n_tests++;
            if (perf_instr !== 16'(m_instr) || perf_bubble !== 16'(m_bubble)) begin
                n_fail++;
                $display("FAIL perf[%0d]: got instr=%0d bubble=%0d expected instr=%0d bubble=%0d",
                         i, perf_instr, perf_bubble, m_instr, m_bubble);
            end
`endif
        end
    endtask

    initial begin
        drive(1, 0, 16'h0, 32'h0, 0, 0);
`ifdef FD_PERF_CNT_EN
        m_instr = 0;
        m_bubble = 0;
`endif
        @(negedge clk);
        test_reset();
        test_two_word();
        test_stall();
        test_flush();
        test_gap();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
